// File: rtl/fu_pkg.sv
// Shared types for the function-unit sequencer:
// FS codes, instruction classes, branch conditions, states, control word.
package fu_pkg;

  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_INC  = 4'b0001;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_ADDC = 4'b0011;
  localparam logic [3:0] FS_ADNB = 4'b0100;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_DEC  = 4'b0110;
  localparam logic [3:0] FS_TRA  = 4'b0111;
  localparam logic [3:0] FS_AND  = 4'b1000;
  localparam logic [3:0] FS_OR   = 4'b1001;
  localparam logic [3:0] FS_XOR  = 4'b1010;
  localparam logic [3:0] FS_NOT  = 4'b1011;
  localparam logic [3:0] FS_MOVB = 4'b1100;
  localparam logic [3:0] FS_SRB  = 4'b1101;
  localparam logic [3:0] FS_SLB  = 4'b1110;
  localparam logic [3:0] FS_HOLD = 4'b1111;

  typedef enum logic [2:0] {
    CL_NOP  = 3'b000,
    CL_LDI  = 3'b001,
    CL_LD   = 3'b010,
    CL_ST   = 3'b011,
    CL_BRC  = 3'b100,
    CL_HALT = 3'b101,
    CL_RSV6 = 3'b110,
    CL_RSV7 = 3'b111
  } cls_e;

  typedef enum logic [2:0] {
    CC_Z   = 3'b000,
    CC_NZ  = 3'b001,
    CC_N   = 3'b010,
    CC_C   = 3'b011,
    CC_V   = 3'b100,
    CC_AL  = 3'b101,
    CC_NV6 = 3'b110,
    CC_NV7 = 3'b111
  } cond_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_FLAG   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic [3:0]  fs;
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic        mb;
    logic        md;
    logic        rw;
    logic        mw;
    logic [15:0] konst;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    fs: FS_HOLD, da: 3'd0, aa: 3'd0, ba: 3'd0,
    mb: 1'b0, md: 1'b0, rw: 1'b0, mw: 1'b0,
    konst: 16'h0000
  };

  // Flags are packed {V,C,N,Z}
  function automatic logic cond_true(cond_e c,
                                     logic [3:0] f);
    logic t;
    t = 1'b0;
    case (c)
      CC_Z:    t = f[0];
      CC_NZ:   t = !f[0];
      CC_N:    t = f[1];
      CC_C:    t = f[2];
      CC_V:    t = f[3];
      CC_AL:   t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fu_sequencer_if.sv
// Instruction fetch port: request/acknowledge with
// same-cycle data.
interface fu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            ireq;
  logic [PC_W-1:0] iaddr;
  logic            iack;
  logic [15:0]     idata;

  modport master (
    output ireq, iaddr,
    input  iack, idata
  );

  modport slave (
    input  ireq, iaddr,
    output iack, idata
  );
endinterface

// File: rtl/fu_ctrl_decode.sv
// Combinational instruction decode: IR to control
// word, instruction class and reserved-opcode flag.
module fu_ctrl_decode
  import fu_pkg::*;
(
  input  logic [15:0] ir_i,
  output ctrl_t       ctrl_o,
  output logic        alu_o,
  output cls_e        cls_o,
  output logic        rsv_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    alu_o  = ir_i[15];
    cls_o  = cls_e'(ir_i[14:12]);
    rsv_o  = 1'b0;
    if (ir_i[15]) begin
      ctrl_o.fs = ir_i[14:11];
      ctrl_o.da = ir_i[10:8];
      ctrl_o.aa = ir_i[7:5];
      ctrl_o.ba = ir_i[4:2];
      ctrl_o.rw = 1'b1;
    end else begin
      unique case (cls_o)
        CL_LDI: begin
          ctrl_o.fs    = FS_MOVB;
          ctrl_o.da    = ir_i[11:9];
          ctrl_o.mb    = 1'b1;
          ctrl_o.rw    = 1'b1;
          ctrl_o.konst = {8'h00, ir_i[7:0]};
        end
        CL_LD: begin
          ctrl_o.da = ir_i[11:9];
          ctrl_o.aa = ir_i[8:6];
          ctrl_o.md = 1'b1;
          ctrl_o.rw = 1'b1;
        end
        CL_ST: begin
          ctrl_o.aa = ir_i[8:6];
          ctrl_o.ba = ir_i[5:3];
          ctrl_o.mw = 1'b1;
        end
        CL_RSV6, CL_RSV7: rsv_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fu_sequencer.sv
// Multi-cycle control sequencer: fetches, decodes and
// issues control words; resolves branches on latched flags.
module fu_sequencer
  import fu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  fu_sequencer_if.master ibus,
  output logic [3:0]    FS,
  output logic [2:0]    DA,
  output logic [2:0]    AA,
  output logic [2:0]    BA,
  output logic          MB,
  output logic [15:0]   const_out,
  output logic          MD,
  output logic          RW,
  output logic          MW,
  input  logic          V,
  input  logic          C,
  input  logic          N,
  input  logic          Z,
  output logic          busy,
  output logic          halted,
  output logic          illegal
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      flg_q, flg_d;
  logic            ill_q, ill_d;

  ctrl_t           dec;
  ctrl_t           ctrl;
  logic            is_alu;
  cls_e            cls;
  logic            rsv;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;
  logic            taken;

  fu_ctrl_decode u_dec (
    .ir_i   (ir_q),
    .ctrl_o (dec),
    .alu_o  (is_alu),
    .cls_o  (cls),
    .rsv_o  (rsv)
  );

  // Truncating the sign-extended offset gives mod 2^PC_W wrap
  assign pc_inc = pc_q + PC_W'(1);
  assign br_off = PC_W'({{23{ir_q[8]}}, ir_q[8:0]});
  assign taken  = (cls == CL_BRC) &&
                  cond_true(cond_e'(ir_q[11:9]), flg_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flg_d      = flg_q;
    ill_d      = ill_q;
    ctrl       = CTRL_IDLE;
    ibus.ireq  = 1'b0;
    ibus.iaddr = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ibus.ireq = 1'b1;
        if (ibus.iack) begin
          ir_d    = ibus.idata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        ctrl = dec;
        if (is_alu) begin
          state_d = S_FLAG;
        end else if (cls == CL_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = taken ? pc_inc + br_off : pc_inc;
          if (rsv) ill_d = 1'b1;
        end
      end
      S_FLAG: begin
        flg_d   = {V, C, N, Z};
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flg_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flg_q   <= flg_d;
      ill_q   <= ill_d;
    end
  end

  assign FS        = ctrl.fs;
  assign DA        = ctrl.da;
  assign AA        = ctrl.aa;
  assign BA        = ctrl.ba;
  assign MB        = ctrl.mb;
  assign MD        = ctrl.md;
  assign RW        = ctrl.rw;
  assign MW        = ctrl.mw;
  assign const_out = ctrl.konst;
  assign busy      = (state_q != S_IDLE) &&
                     (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign illegal   = ill_q;

endmodule

// File: tb/tb_fu_sequencer.sv
// Directed bench for fu_sequencer: fetch handshake,
// decode, branches, wrap, illegal, halt and reset abort.
module tb_fu_sequencer;

  logic        CLK;
  logic        RESET;
  logic        start;
  logic [3:0]  FS;
  logic [2:0]  DA, AA, BA;
  logic        MB, MD, RW, MW;
  logic [15:0] const_out;
  logic        V, C, N, Z;
  logic        busy, halted, illegal;

  int n_assert;
  int n_fail;

  fu_sequencer_if #(.PC_W(8)) ibus ();

  fu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .ibus      (ibus),
    .FS        (FS),
    .DA        (DA),
    .AA        (AA),
    .BA        (BA),
    .MB        (MB),
    .const_out (const_out),
    .MD        (MD),
    .RW        (RW),
    .MW        (MW),
    .V         (V),
    .C         (C),
    .N         (N),
    .Z         (Z),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Serve one fetch: wait for ireq, hold for waits cycles,
  // then ack; returns one cycle later (in DECODE).
  task automatic fetch(input logic [15:0] instr,
                       input logic [7:0] exp_a,
                       input int waits,
                       input string tag);
    int n;
    n = 0;
    while (!ibus.ireq && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ireq"}, 32'(ibus.ireq), 32'd1);
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_iaddr_w"}, 32'(ibus.iaddr), 32'(exp_a));
      tick();
    end
    chk({tag, "_iaddr"}, 32'(ibus.iaddr), 32'(exp_a));
    ibus.iack  = 1'b1;
    ibus.idata = instr;
    tick();
    ibus.iack  = 1'b0;
    ibus.idata = 16'h0000;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    RESET      = 1'b1;
    start      = 1'b0;
    ibus.iack  = 1'b0;
    ibus.idata = 16'h0000;
    {V, C, N, Z} = 4'b0000;
    tick();
    tick();
    chk("rst_ireq", 32'(ibus.ireq), 32'd0);
    chk("rst_rw", 32'(RW), 32'd0);
    chk("rst_mw", 32'(MW), 32'd0);
    chk("rst_fs", 32'(FS), 32'hF);
    chk("rst_regs", 32'({DA, AA, BA}), 32'd0);
    chk("rst_mbmd", 32'({MB, MD}), 32'd0);
    chk("rst_const", 32'(const_out), 32'd0);
    chk("rst_stat", 32'({busy, halted, illegal}), 32'd0);
    RESET = 1'b0;
    tick();

    // Ack without a request must be ignored
    ibus.iack  = 1'b1;
    ibus.idata = 16'h1205;
    tick();
    chk("idle_ack_ireq", 32'(ibus.ireq), 32'd0);
    chk("idle_ack_busy", 32'(busy), 32'd0);
    ibus.iack  = 1'b0;
    ibus.idata = 16'h0000;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);

    // PC0: LDI R1,0x05 with two wait cycles
    fetch(16'h1205, 8'h00, 2, "ldi");
    chk("ldi_dec_rw", 32'(RW), 32'd0);
    tick();
    chk("ldi_da", 32'(DA), 32'd1);
    chk("ldi_fs", 32'(FS), 32'hC);
    chk("ldi_mb", 32'(MB), 32'd1);
    chk("ldi_const", 32'(const_out), 32'h0005);
    chk("ldi_rw", 32'(RW), 32'd1);
    tick();
    chk("ldi_rw_end", 32'(RW), 32'd0);
    chk("ldi_fs_end", 32'(FS), 32'hF);

    // PC1: ALU FS=0100 DR0 SA1 SB0, flags V0 C1 N0 Z1
    fetch(16'hA020, 8'h01, 0, "alu");
    tick();
    chk("alu_fs", 32'(FS), 32'h4);
    chk("alu_aa", 32'(AA), 32'd1);
    chk("alu_da", 32'(DA), 32'd0);
    chk("alu_rw", 32'(RW), 32'd1);
    {V, C, N, Z} = 4'b0101;
    tick();
    chk("alu_flag_ireq", 32'(ibus.ireq), 32'd0);
    chk("alu_flag_busy", 32'(busy), 32'd1);
    chk("alu_flag_rw", 32'(RW), 32'd0);
    tick();
    {V, C, N, Z} = 4'b0000;
    chk("alu_4cyc_ireq", 32'(ibus.ireq), 32'd1);

    // PC2: BRC Z +3 on latched Z=1 (live Z now 0)
    fetch(16'h4003, 8'h02, 0, "brz");
    tick();
    chk("brz_exec_fs", 32'(FS), 32'hF);
    chk("brz_exec_st", 32'({RW, MW}), 32'd0);
    // PC6: BRC !Z +5, not taken
    fetch(16'h4205, 8'h06, 0, "brnz");
    // PC7: BRC always -1, back to 7
    fetch(16'h4BFF, 8'h07, 0, "bral_m1");
    // PC7: BRC always +247 -> 0xFF
    fetch(16'h4AF7, 8'h07, 0, "bral_ff");
    // PC 0xFF: NOP wraps to 0
    fetch(16'h0000, 8'hFF, 0, "nop_ff");
    // PC0: BRC always -3 -> 0xFE
    fetch(16'h4BFD, 8'h00, 0, "bral_fe");
    // PC 0xFE: BRC always +4 -> 0x03
    fetch(16'h4A04, 8'hFE, 0, "bral_wr");

    // PC3: reserved class 110
    fetch(16'h6000, 8'h03, 0, "ill");
    tick();
    chk("ill_exec_st", 32'({RW, MW}), 32'd0);
    tick();
    chk("ill_sticky", 32'(illegal), 32'd1);

    // PC4: LD R2,[R3]
    fetch(16'h24C0, 8'h04, 0, "ld");
    tick();
    chk("ld_ctl", 32'({MD, RW, MW, MB}), 32'b1100);
    chk("ld_da", 32'(DA), 32'd2);
    chk("ld_aa", 32'(AA), 32'd3);

    // PC5: ST [R1],R2
    fetch(16'h3050, 8'h05, 0, "st");
    tick();
    chk("st_ctl", 32'({MD, RW, MW}), 32'b001);
    chk("st_aa", 32'(AA), 32'd1);
    chk("st_ba", 32'(BA), 32'd2);
    tick();
    chk("st_mw_end", 32'(MW), 32'd0);

    // PC6: HALT, then start and a stray ack are ignored
    fetch(16'h5000, 8'h06, 0, "halt");
    tick();
    tick();
    chk("halt_stat", 32'({busy, halted}), 32'b01);
    chk("halt_ireq", 32'(ibus.ireq), 32'd0);
    start      = 1'b1;
    ibus.iack  = 1'b1;
    ibus.idata = 16'h1205;
    tick();
    start      = 1'b0;
    ibus.iack  = 1'b0;
    ibus.idata = 16'h0000;
    tick();
    chk("halt_hold", 32'({halted, ibus.ireq, RW}), 32'b100);
    chk("halt_ill", 32'(illegal), 32'd1);

    RESET = 1'b1;
    #1;
    chk("rst2_stat", 32'({halted, illegal}), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // Load Z=1 into flags again, then abort a ST
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(16'hA020, 8'h00, 1, "alu2");
    tick();
    {V, C, N, Z} = 4'b0001;
    tick();
    tick();
    {V, C, N, Z} = 4'b0000;
    fetch(16'h3050, 8'h01, 0, "st2");
    tick();
    chk("st2_mw", 32'(MW), 32'd1);
    RESET = 1'b1;
    #1;
    chk("abort_mw", 32'(MW), 32'd0);
    chk("abort_stat", 32'({busy, ibus.ireq}), 32'd0);
    chk("abort_fs", 32'(FS), 32'hF);
    tick();
    RESET = 1'b0;
    tick();

    // PC back to 0 and FLG cleared: BRC Z not taken
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(16'h4003, 8'h00, 0, "brz2");
    fetch(16'h0000, 8'h01, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_sequencer.md
# fu_sequencer

Multi-cycle control sequencer that drives the 16-bit function unit and register file from a 16-bit instruction stream. Fetches instructions over a req/ack port, decodes them into a control word (function select, register addresses, constant, write strobes), and consumes the function unit's V/C/N/Z status to resolve conditional branches. It is the control-side counterpart of the function unit: it issues `FS` and reads back the flags.

## Interface
- `PC_W`, 8, program counter width.
- `RESET_PC`, 0, PC value loaded on reset.

- `CLK`  in  1  clock, rising edge.
- `RESET`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin execution from PC; sampled only in IDLE.
- `ireq`  out  1  instruction fetch request.
- `iaddr`  out  PC_W  fetch address; equals PC while `ireq`=1.
- `iack`  in  1  fetch acknowledge; `idata` valid in the same cycle.
- `idata`  in  16  instruction word.
- `FS`  out  4  function select to function unit.
- `DA`, `AA`, `BA`  out  3 each  destination and source register addresses.
- `MB`  out  1  1 = B operand from `const_out`.
- `const_out`  out  16  zero-extended immediate.
- `MD`  out  1  1 = register write data from memory.
- `RW`  out  1  register write strobe, one cycle.
- `MW`  out  1  memory write strobe, one cycle.
- `V`, `C`, `N`, `Z`  in  1 each  function unit status.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set on reserved opcode.

## Operation
- Encoding: `idata[15]`=1 is an ALU op with FS=[14:11], DR=[10:8], SA=[7:5], SB=[4:2]; [1:0] ignored.
- `idata[15]`=0: class=[14:12], DR=[11:9], SA=[8:6], SB=[5:3], imm8=[7:0], cond=[11:9], off9=[8:0] (signed).
- Class 000 NOP.
- Class 001 LDI: DR ← imm8; FS=1100, MB=1, RW.
- Class 010 LD: DR ← M[R[SA]]; MD=1, RW.
- Class 011 ST: M[R[SA]] ← R[SB]; MW.
- Class 100 BRC: if cond true, PC ← PC+1+sext(off9); else PC+1. All PC arithmetic is mod 2^PC_W.
  - cond 000 Z, 001 !Z, 010 N, 011 C, 100 V, 101 always; 110/111 never taken.
- Class 101 HALT.
- Classes 110/111: execute as NOP, set `illegal`.
- Flag register FLG={V,C,N,Z} is loaded only in FLAG state (ALU ops). Branches test FLG, never the live inputs. Reset value 0.
- States and transitions:
  - IDLE → FETCH on `start`.
  - FETCH holds `ireq`=1 and `iaddr`=PC until `iack`; on `iack` it latches IR and goes → DECODE.
  - DECODE → EXEC.
  - EXEC drives the control word for exactly one cycle (RW/MW pulse here). From EXEC: ALU op → FLAG; HALT → HALT; everything else → FETCH with PC updated.
  - FLAG: latch the flags, PC+1 → FETCH.
  - HALT is terminal until RESET.
- Outside EXEC: `RW`=`MW`=`MB`=`MD`=0 and `FS`=1111 (hold).

## Timing
- Reset (async): state IDLE, PC=RESET_PC, IR=0, FLG=0. Outputs `ireq`=0, `RW`=`MW`=0, `FS`=1111, `DA`=`AA`=`BA`=0, `MB`=`MD`=0, `const_out`=0, `busy`=0, `halted`=0, `illegal`=0.
- Cycle counts from `iack` cycle, with zero-wait ack:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, FLAG).
  - All other classes: 3 cycles.
- `iack` while `ireq`=0 is ignored. `ireq` stays high across multiple wait cycles without `iaddr` changing.
- `start` outside IDLE is ignored, including in HALT.
- RESET asserted mid-instruction: control strobes drop immediately, with no partial RW/MW. No flag update occurs.
- PC wraps from 2^PC_W−1 to 0; branch targets wrap the same way.

## Structure
- Package `fu_pkg`:
  - FS code constants (0000–1111 as the function unit defines).
  - Class codes and condition codes.
  - State enum {IDLE, FETCH, DECODE, EXEC, FLAG, HALT}.
  - Control-word struct.
- Sub-module `fu_ctrl_decode`: purely combinational, IR → control word and class. The sequencer owns all state, PC, and FLG.

## Test plan
- Reset, then `start`; fetch LDI R1,0x05 (0x1205) with `iack` after 2 wait cycles → `iaddr`=0 held 3 cycles; in EXEC `DA`=1, `FS`=1100, `MB`=1, `const_out`=0x0005, `RW` pulse of 1 cycle.
- ALU op 0xA020 (FS=0100, DR=0, SA=1, SB=0) with flag inputs V=0, C=1, N=0, Z=1 → 4 cycles per instruction. Next BRC Z with off9=+3 at PC=1 → next `iaddr`=5.
- BRC !Z after Z=1 → not taken, `iaddr`=PC+1. BRC always with off9=−1 at PC=0 → `iaddr`=0.
- PC=0xFF with NOP → next `iaddr`=0x00. Branch at 0xFE with off9=+4 → `iaddr`=0x03.
- Opcode 0x6000 → `illegal`=1, no RW/MW, execution continues. HALT (0x5000) → `halted`=1, `busy`=0, `start` ignored.
- RESET asserted during EXEC of ST → `MW` drops in the same cycle, PC=0, state IDLE, FLG=0.
